// File: rtl/wm8731_pkg.sv
// rtl/wm8731_pkg.sv - shared widths, frame bit positions and sample pair type for the WM8731 DAC transmitter
package wm8731_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int FRAME_BITS = 32;

    // Bit-counter values at which each channel's MSB leaves on dacdat
    localparam logic [4:0] LEFT_MSB_BIT  = 5'd0;
    localparam logic [4:0] RIGHT_MSB_BIT = 5'd16;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } sample_pair_t;

endpackage

// File: rtl/wm8731_dac_tx_if.sv
// rtl/wm8731_dac_tx_if.sv - valid/ready sample pair handshake between the audio datapath and the DAC transmitter
interface wm8731_dac_tx_if;
    import wm8731_pkg::*;

    logic                sample_valid;
    logic                sample_ready;
    logic [SAMPLE_W-1:0] sample_l;
    logic [SAMPLE_W-1:0] sample_r;

    modport master (
        output sample_valid,
        output sample_l,
        output sample_r,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_l,
        input  sample_r,
        output sample_ready
    );

endinterface

// File: rtl/wm8731_clk_div.sv
// rtl/wm8731_clk_div.sv - free-running divide-by-2*HALF clock generator with a rising-toggle strobe
module wm8731_clk_div #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic reset,
    output logic clk_out,
    output logic rise
);

    localparam int            CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt;
    logic          at_last;

    assign at_last = (cnt == LAST);
    // High in the cycle whose closing edge drives clk_out 0->1, so users can
    // update their outputs on the very same edge as the divided clock rises.
    assign rise    = at_last & ~clk_out;

    // Half-period counter; clk_out flips each time it reaches HALF-1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (at_last) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
        end else begin
            cnt     <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/wm8731_dac_tx.sv
// rtl/wm8731_dac_tx.sv - WM8731 left-justified DAC serial transmitter; WM8731_DAC_TX_UNDERRUN_CNT_EN adds underrun_cnt
module wm8731_dac_tx
    import wm8731_pkg::*;
#(
    parameter int MCLK_HALF = 2,
    parameter int BCLK_HALF = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    wm8731_dac_tx_if.slave        smp,
    output logic                  m_clk,
    output logic                  b_clk,
    output logic                  dac_lr_clk,
    output logic                  dacdat,
    output logic                  underrun
`ifdef WM8731_DAC_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]           underrun_cnt
`endif
);

    logic                  b_rise;
    logic [4:0]            bit_cnt;
    logic [4:0]            bit_nxt;
    logic [FRAME_BITS-1:0] shreg;
    sample_pair_t          buf_pair;
    logic                  buf_full;
    logic                  frame_start;
    logic                  accept;

    wm8731_clk_div #(.HALF(MCLK_HALF)) u_mclk_div (
        .clk     (clk),
        .reset   (reset),
        .clk_out (m_clk),
        .rise    ()
    );

    wm8731_clk_div #(.HALF(BCLK_HALF)) u_bclk_div (
        .clk     (clk),
        .reset   (reset),
        .clk_out (b_clk),
        .rise    (b_rise)
    );

    assign bit_nxt          = bit_cnt + 5'd1;
    assign frame_start      = b_rise && (bit_nxt == LEFT_MSB_BIT);
    assign accept           = smp.sample_valid && !buf_full;
    assign smp.sample_ready = !buf_full;

    // One-deep holding buffer; a frame start reads the state before any
    // same-cycle acceptance, so a colliding pair waits for the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_full <= 1'b0;
            buf_pair <= '0;
        end else begin
            if (frame_start) begin
                buf_full <= 1'b0;
            end
            if (accept) begin
                buf_full <= 1'b1;
                buf_pair <= '{left: smp.sample_l, right: smp.sample_r};
            end
        end
    end

    // Bit counter, frame clock and shifter, all advancing on b_clk rising edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt    <= 5'd31;
            shreg      <= '0;
            dacdat     <= 1'b0;
            dac_lr_clk <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (b_rise) begin
                bit_cnt <= bit_nxt;
                if (frame_start) begin
                    dac_lr_clk <= 1'b1;
                    if (buf_full) begin
                        dacdat <= buf_pair.left[SAMPLE_W-1];
                        shreg  <= {buf_pair[FRAME_BITS-2:0], 1'b0};
                    end else begin
                        dacdat   <= 1'b0;
                        shreg    <= '0;
                        underrun <= 1'b1;
                    end
                end else begin
                    if (bit_nxt == RIGHT_MSB_BIT) begin
                        dac_lr_clk <= 1'b0;
                    end
                    dacdat <= shreg[FRAME_BITS-1];
                    shreg  <= {shreg[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

`ifdef WM8731_DAC_TX_UNDERRUN_CNT_EN
    // Saturating tally of frames that started with nothing to send
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underrun_cnt <= 16'd0;
        end else if (underrun && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wm8731_dac_tx.sv
// tb/tb_wm8731_dac_tx.sv - randomized self-checking bench for wm8731_dac_tx against a cycle-arithmetic frame model
module tb_wm8731_dac_tx;
    import wm8731_pkg::*;

    localparam int MH        = 2;
    localparam int BH        = 4;
    localparam int FRAME_CYC = 64 * BH;
    localparam int CLK_NS    = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic m_clk, b_clk, dac_lr_clk, dacdat, underrun;
`ifdef WM8731_DAC_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    wm8731_dac_tx_if sif ();

    wm8731_dac_tx #(.MCLK_HALF(MH), .BCLK_HALF(BH)) dut (
        .clk          (clk),
        .reset        (reset),
        .smp          (sif),
        .m_clk        (m_clk),
        .b_clk        (b_clk),
        .dac_lr_clk   (dac_lr_clk),
        .dacdat       (dacdat),
        .underrun     (underrun)
`ifdef WM8731_DAC_TX_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #(CLK_NS / 2) clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: cycle index since reset release, buffered pair, and the
    // 32-bit word assigned to each frame number.
    int          c;
    bit          exp_full;
    logic [31:0] exp_buf;
    logic [31:0] frame_word [int];
    bit          frame_under [int];
    int          exp_ucnt;
    bit          last_exp_under;
    bit          last_accept;
    bit          prev_lr;
    bit          have_lr;
    time         last_lr_rise;
    logic [15:0] idx;

    task automatic check_reset_values(input string tag);
        check({tag, "_m_clk"}, m_clk, 0);
        check({tag, "_b_clk"}, b_clk, 0);
        check({tag, "_lr"}, dac_lr_clk, 0);
        check({tag, "_dacdat"}, dacdat, 0);
        check({tag, "_underrun"}, underrun, 0);
        check({tag, "_ready"}, sif.sample_ready, 1);
`ifdef WM8731_DAC_TX_UNDERRUN_CNT_EN
        check({tag, "_ucnt"}, underrun_cnt, 0);
`endif
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b1;
        sif.sample_valid = 1'b0;
        #1 check_reset_values("reset_now");
        repeat (5) @(posedge clk);
        #1 check_reset_values("reset_held");
        #4 reset = 1'b0;
        c = 0;
        exp_full = 1'b0;
        exp_buf = '0;
        frame_word.delete();
        frame_under.delete();
        exp_ucnt = 0;
        last_exp_under = 1'b0;
        prev_lr = 1'b0;
        have_lr = 1'b0;
    endtask

    task automatic step();
        bit          v;
        bit          ready_before;
        bit          fs;
        logic [31:0] pair;
        int          k, off, bit_i;
        logic        e_lr, e_dat, e_und;
        v = sif.sample_valid;
        pair = {sif.sample_l, sif.sample_r};
        ready_before = !exp_full;
        @(posedge clk);
        c++;
        if (last_exp_under && exp_ucnt < 65535) exp_ucnt++;
        fs = (c >= BH) && (((c - BH) % FRAME_CYC) == 0);
        if (fs) begin
            k = (c - BH) / FRAME_CYC;
            if (exp_full) begin
                frame_word[k]  = exp_buf;
                frame_under[k] = 1'b0;
                exp_full       = 1'b0;
            end else begin
                frame_word[k]  = '0;
                frame_under[k] = 1'b1;
            end
        end
        last_accept = v && ready_before;
        if (last_accept) begin
            exp_full = 1'b1;
            exp_buf  = pair;
        end
        #1;
        if (c < BH) begin
            e_lr = 0; e_dat = 0; e_und = 0;
        end else begin
            k     = (c - BH) / FRAME_CYC;
            off   = (c - BH) % FRAME_CYC;
            bit_i = off / (2 * BH);
            e_lr  = (bit_i < 16);
            e_dat = frame_word[k][31 - bit_i];
            e_und = (off == 0) && frame_under[k];
        end
        check("m_clk", m_clk, (c / MH) % 2);
        check("b_clk", b_clk, (c / BH) % 2);
        check("dac_lr_clk", dac_lr_clk, e_lr);
        check("dacdat", dacdat, e_dat);
        check("underrun", underrun, e_und);
        check("sample_ready", sif.sample_ready, !exp_full);
`ifdef WM8731_DAC_TX_UNDERRUN_CNT_EN
        check("underrun_cnt", underrun_cnt, exp_ucnt);
`endif
        if (dac_lr_clk && !prev_lr) begin
            if (have_lr) check("lr_period_ns", 32'($time - last_lr_rise), FRAME_CYC * CLK_NS);
            last_lr_rise = $time;
            have_lr = 1'b1;
        end
        prev_lr = dac_lr_clk;
        last_exp_under = e_und;
    endtask

    task automatic run_idle(input int n);
        repeat (n) begin
            sif.sample_valid = 1'b0;
            step();
        end
    endtask

    task automatic send_one(input logic [15:0] l, input logic [15:0] r);
        int guard = 0;
        while (exp_full && guard < 2 * FRAME_CYC) begin
            sif.sample_valid = 1'b0;
            step();
            guard++;
        end
        if (guard >= 2 * FRAME_CYC) check("send_wait", 0, 1);
        sif.sample_valid = 1'b1;
        sif.sample_l = l;
        sif.sample_r = r;
        step();
        sif.sample_valid = 1'b0;
    endtask

    task automatic run_stream(input int n);
        repeat (n) begin
            sif.sample_valid = 1'b1;
            sif.sample_l = idx;
            sif.sample_r = 16'h8000 | idx;
            step();
            if (last_accept) idx = idx + 16'd1;
        end
        sif.sample_valid = 1'b0;
    endtask

    task automatic run_random(input int n);
        repeat (n) begin
            sif.sample_valid = ($urandom_range(0, 3) == 0);
            sif.sample_l = 16'($urandom);
            sif.sample_r = 16'($urandom);
            step();
        end
        sif.sample_valid = 1'b0;
    endtask

    // Present a pair whose acceptance edge is exactly a frame-start edge
    task automatic collide();
        int guard = 0;
        while (!(!exp_full && (((c + 1 - BH) % FRAME_CYC) == 0)) && guard < 3 * FRAME_CYC) begin
            sif.sample_valid = 1'b0;
            step();
            guard++;
        end
        if (guard >= 3 * FRAME_CYC) check("collide_wait", 0, 1);
        sif.sample_valid = 1'b1;
        sif.sample_l = 16'h1234;
        sif.sample_r = 16'h5678;
        step();
        sif.sample_valid = 1'b0;
        check("collide_underrun", underrun, 1);
        check("collide_held", exp_full, 1);
    endtask

    initial begin
        sif.sample_valid = 1'b0;
        sif.sample_l = '0;
        sif.sample_r = '0;
        idx = 16'd1;
        do_reset();
        run_idle(2 * FRAME_CYC);
        send_one(16'hA5A5, 16'h3C3C);
        run_idle(2 * FRAME_CYC);
        run_stream(4 * FRAME_CYC);
        collide();
        run_idle(2 * FRAME_CYC + 10);
        run_random(3 * FRAME_CYC);
        send_one(16'hBEEF, 16'hCAFE);
        run_idle(FRAME_CYC / 2);
        do_reset();
        run_idle(FRAME_CYC + 10);
        run_random(2 * FRAME_CYC);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wm8731_dac_tx.md
# wm8731_dac_tx

Synthesizable transmitter for the WM8731 DAC serial audio port. It accepts 16-bit left/right sample pairs through a valid/ready handshake and generates `m_clk`, `b_clk`, `dac_lr_clk` and `dacdat`. The frame format is left-justified, MSB first: 16 left bits while `dac_lr_clk` is high, then 16 right bits while it is low. The block sits between the audio datapath and the codec pins and is the driving end of the link that the DAC functional model samples.

## Interface
- `MCLK_HALF`, default 2: `clk` cycles per `m_clk` half-period (≥1).
- `BCLK_HALF`, default 4: `clk` cycles per `b_clk` half-period (≥1).
- `clk`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `sample_valid`  input  1  a new sample pair is presented.
- `sample_ready`  output  1  holding buffer empty; transfer occurs when valid && ready.
- `sample_l`  input  16  left sample.
- `sample_r`  input  16  right sample.
- `m_clk`  output  1  codec master clock.
- `b_clk`  output  1  bit clock.
- `dac_lr_clk`  output  1  frame clock: high = left, low = right.
- `dacdat`  output  1  serial data.
- `underrun`  output  1  one-cycle pulse when a frame starts with an empty buffer.

## Operation
- Reset values: `m_clk`=0, `b_clk`=0, `dac_lr_clk`=0, `dacdat`=0, `underrun`=0, `sample_ready`=1, bit counter=31, holding buffer empty.
- `m_clk`: free-running divider that toggles every `MCLK_HALF` cycles.
- `b_clk`: free-running divider that toggles every `BCLK_HALF` cycles and is independent of `m_clk` phase.
- On each `b_clk` 0→1 transition, the 5-bit bit counter increments and wraps 31→0.
- In the same cycle, `dacdat` is loaded with the MSB of the 32-bit shift register, and the register shifts left with zero fill.
- Frame start is the bit counter wrapping to 0. In that cycle:
  - `dac_lr_clk` goes to 1.
  - If the buffer is full, the shift register loads `{sample_l, sample_r}`, the buffer empties, and the MSB of `sample_l` goes out on `dacdat` in that same cycle.
  - If the buffer is empty, the shift register loads zeros and `underrun` pulses.
- When the bit counter reaches 16, `dac_lr_clk` goes to 0 and the MSB of the right sample goes out.
- Handshake:
  - `sample_ready` = buffer empty.
  - On acceptance, the buffer captures both words and `sample_ready` drops on the next cycle.
  - `sample_ready` rises again the cycle after a frame start consumes the buffer.
  - `sample_valid` while not ready has no effect.
- Simultaneous acceptance and frame start in the same cycle:
  - The frame sees the buffer as empty, so `underrun` pulses and zeros are sent.
  - The accepted pair stays buffered for the next frame. There is no bypass path.
- Reset asserted mid-frame: all state returns to reset values immediately, and the buffered pair is discarded.

## Timing
- Data changes only on `b_clk` rising edges. Data is stable across every `b_clk` falling edge, which is where the receiver samples.
- The first `b_clk` rising edge, and therefore the first frame start, occurs `BCLK_HALF` cycles after `reset` deasserts.
- Frame period is 64·`BCLK_HALF` `clk` cycles.
- `dac_lr_clk` changes in the same cycle as a `b_clk` rising edge.
- Latency: a pair accepted at least 1 cycle before a frame start appears in that frame. Worst case is one frame plus 1 cycle.

## Configuration
- `WM8731_DAC_TX_UNDERRUN_CNT_EN` defined:
  - Adds output `underrun_cnt` [15:0], reset to 0.
  - It increments on each `underrun` pulse and saturates at 0xFFFF.
- `WM8731_DAC_TX_UNDERRUN_CNT_EN` undefined:
  - The port and the counter are absent.
  - The `underrun` pulse is unchanged.

## Structure
- Package `wm8731_pkg` holds:
  - `SAMPLE_W`=16 and `FRAME_BITS`=32.
  - `LEFT_MSB_BIT`=0 and `RIGHT_MSB_BIT`=16.
  - typedef `sample_pair_t` (packed left, right).
- Sub-module `wm8731_clk_div`:
  - parameter `HALF`; ports `clk`, `reset`, `clk_out`, `rise` (one-cycle pulse on the 0→1 toggle).
  - Instantiated twice: once for `m_clk`, once for `b_clk`.

## Test plan
- Reset check: hold `reset` high for 5 cycles → `m_clk`/`b_clk`/`dac_lr_clk`/`dacdat`/`underrun`=0 and `sample_ready`=1. Assert reset again mid-frame → same values immediately.
- Clock frequencies: 10 ns `clk`, `MCLK_HALF`=2, `BCLK_HALF`=4 → `m_clk` period 40 ns, `b_clk` period 80 ns, `dac_lr_clk` period 2560 ns. Measure edge-to-edge.
- Data framing: send L=0xA5A5, R=0x3C3C → serial-read on `b_clk` falling edges after `dac_lr_clk` rises returns exactly 0xA5A5 / 0x3C3C, and `underrun` stays 0 for that frame.
- Underrun: no `sample_valid` after reset → first frame all zeros, `underrun` high for exactly 1 cycle at frame start, pulse repeats every 2560 ns.
- Streaming: keep `sample_valid` high with an incrementing pattern 0x0001/0x8001, 0x0002/0x8002, … → every frame carries the next pair, with no skips or repeats. `sample_ready` low from acceptance until the consuming frame start.
- Collision and counter: present a pair exactly in the frame-start cycle → `underrun` pulses, zeros sent, pair sent in the following frame. With `WM8731_DAC_TX_UNDERRUN_CNT_EN` defined, `underrun_cnt` increments by 1.
